// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer driving one registered-carry full-adder cell, LSB first.
// Latency: done rises WIDTH edges after the edge that samples start; one add per WIDTH+1 busy cycles.
// Backpressure: none queued; start is only sampled in IDLE and dropped while RUN/DONE.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         request, sampled only when idle, together with a, b, cin (and sub)
//   a, b, cin     WIDTH-bit operands and carry-in
//   sub           subtract select (present only when SERIAL_SUB_EN is defined)
//   busy          high from the cycle after start is accepted through the done cycle
//   done          one-cycle pulse; sum/cout valid from this cycle on
//   sum, cout     registered result, held until the next done
//
// Build option: define SERIAL_SUB_EN to add the sub port ({cout,sum} = a + ~b + 1 when sub=1).

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;   // operand A; vacated MSBs double as the sum accumulator
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Values captured at start (subtract folds into the B operand and carry-in)
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  always_comb begin
    b_load = b;
    c_load = cin;
`ifdef SERIAL_SUB_EN
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end
`endif
  end

  // The shared full-adder cell
  logic bit_s;
  logic bit_c;

  always_comb begin
    bit_s = a_sr[0] ^ b_sr[0] ^ carry;
    bit_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  end

  // As A shifts right, each sum bit enters at the top; after WIDTH shifts
  // a_sr holds the complete result, so no separate accumulator is needed.
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    acc_next = {bit_s, a_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end

        S_RUN: begin
          a_sr  <= acc_next;
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          carry <= bit_c;
          if (cnt == LAST) begin
            // Final bit: publish the whole result at once, never partials.
            // cnt is left at LAST so it never wraps.
            sum   <= acc_next;
            cout  <= bit_c;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
